cdb_arbiter: RTL

- Transmitting end of the common data bus (CDB).
- Collects completed results from NUM_FU execution units (ALU, MUL/DIV, LSU, ...) through per-unit valid/ready handshakes and buffers one result per unit.
- Round-robin arbitration drives one result per cycle onto cdb_pkt.
- The branch unit has a dedicated, non-backpressured path onto cdb_pkt2. That path carries resolution info (br_mispred, br_bit), which also kills or un-speculates results held inside this block.

---
 rtl/cdb_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter -- transmitting end of the common data bus.
//
// Each functional unit hands over one completed result through a valid/ready
// handshake. The result sits in a one-entry hold slot until the round-robin
// arbiter grants it onto cdb_pkt, one broadcast per cycle. The branch unit has
// its own unthrottled path onto cdb_pkt2. Its resolution also squashes held
// results (mispredict) or clears their speculation bit (correct predict).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   fu_valid/ready    per-unit handshake; ready does not depend on valid
//   fu_paddr/data/rob_idx/bmask   per-unit result payload, packed unit-major
//   br_*              branch resolution and link-register write, always taken
//   cdb_pkt           registered arbitrated broadcast
//   cdb_pkt2          registered branch broadcast
//
// The width parameters must match cdb_pkg, which fixes the packet layout.
// -----------------------------------------------------------------------------
package cdb_pkg;
    localparam int PADDR_W = 6;
    localparam int ROB_W   = 5;
    localparam int BMASK_W = 4;
    localparam int BBIT_W  = $clog2(BMASK_W);

    typedef struct packed {
        logic               cdb_broadcast;
        logic [PADDR_W-1:0] cdb_p_addr;
        logic [31:0]        cdb_data;
        logic [ROB_W-1:0]   cdb_rob_idx;
        logic               br_mispred;
        logic [BBIT_W-1:0]  br_bit;
    } cdb_pkt_t;
endpackage

module cdb_arbiter #(
    parameter int NUM_FU  = 4,
    parameter int BMASK_W = cdb_pkg::BMASK_W,
    parameter int PADDR_W = cdb_pkg::PADDR_W,
    parameter int ROB_W   = cdb_pkg::ROB_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FU-1:0]            fu_valid,
    output logic [NUM_FU-1:0]            fu_ready,
    input  logic [NUM_FU*PADDR_W-1:0]    fu_paddr,
    input  logic [NUM_FU*32-1:0]         fu_data,
    input  logic [NUM_FU*ROB_W-1:0]      fu_rob_idx,
    input  logic [NUM_FU*BMASK_W-1:0]    fu_bmask,
    input  logic                         br_valid,
    input  logic                         br_mispred,
    input  logic [$clog2(BMASK_W)-1:0]   br_bit,
    input  logic [PADDR_W-1:0]           br_paddr,
    input  logic [31:0]                  br_data,
    input  logic [ROB_W-1:0]             br_rob_idx,
    input  logic [BMASK_W-1:0]           br_bmask,
    output cdb_pkg::cdb_pkt_t            cdb_pkt,
    output cdb_pkg::cdb_pkt_t            cdb_pkt2
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]  hold_valid;
    logic [PADDR_W-1:0] hold_paddr [NUM_FU];
    logic [31:0]        hold_data  [NUM_FU];
    logic [ROB_W-1:0]   hold_rob   [NUM_FU];
    logic [BMASK_W-1:0] hold_bmask [NUM_FU];
    logic [PTR_W-1:0]   rr_ptr;

    logic               kill_active;
    logic [BMASK_W-1:0] clr_mask;
    logic [NUM_FU-1:0]  hold_kill;
    logic [NUM_FU-1:0]  in_kill;
    logic [NUM_FU-1:0]  cand;
    logic [NUM_FU-1:0]  grant;
    logic [NUM_FU-1:0]  load;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_any;
    cdb_pkg::cdb_pkt_t  pkt_next;
    cdb_pkg::cdb_pkt_t  pkt2_next;

    // Branch resolution acts in the same cycle it arrives, so a squashed
    // result can never win arbitration alongside its mispredict broadcast.
    assign kill_active = br_valid && br_mispred;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        clr_mask = '0;
        if (br_valid && !br_mispred) begin
            clr_mask[br_bit] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            hold_kill[i] = kill_active && hold_bmask[i][br_bit];
            in_kill[i]   = kill_active && fu_bmask[i*BMASK_W + int'(br_bit)];
            cand[i]      = hold_valid[i] && !hold_kill[i];
        end
    end

    // Round-robin scan starting at rr_ptr; the first candidate found wins.
    // NOTE: combinational logic uses blocking assignments so later loop
    // iterations see grant_any as updated by earlier ones.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_FU;
            if (!grant_any && cand[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = PTR_W'(idx);
            end
        end
    end

    // A slot can take a new result when it is empty or is emptied this cycle.
    assign fu_ready = ~hold_valid | grant | hold_kill;
    assign load     = fu_valid & fu_ready;

    always_comb begin
        pkt_next = '0;
        if (grant_any) begin
            pkt_next.cdb_broadcast = 1'b1;
            pkt_next.cdb_p_addr    = hold_paddr[grant_idx];
            pkt_next.cdb_data      = hold_data[grant_idx];
            pkt_next.cdb_rob_idx   = hold_rob[grant_idx];
        end
        // A branch squashed by an older mispredict is dropped entirely.
        pkt2_next.cdb_broadcast = br_valid && !(kill_active && br_bmask[br_bit]);
        pkt2_next.cdb_p_addr    = br_paddr;
        pkt2_next.cdb_data      = br_data;
        pkt2_next.cdb_rob_idx   = br_rob_idx;
        pkt2_next.br_mispred    = br_mispred;
        pkt2_next.br_bit        = br_bit;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            cdb_pkt    <= '0;
            cdb_pkt2   <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (load[i]) begin
                    hold_valid[i] <= !in_kill[i];
                end else if (grant[i] || hold_kill[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            if (grant_any) begin
                rr_ptr <= PTR_W'((int'(grant_idx) + 1) % NUM_FU);
            end
            cdb_pkt  <= pkt_next;
            cdb_pkt2 <= pkt2_next;
        end
    end

    // NOTE: the payload storage has no reset; hold_valid alone decides whether
    // a slot's contents mean anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (load[i]) begin
                hold_paddr[i] <= fu_paddr[i*PADDR_W +: PADDR_W];
                hold_data[i]  <= fu_data[i*32 +: 32];
                hold_rob[i]   <= fu_rob_idx[i*ROB_W +: ROB_W];
                hold_bmask[i] <= fu_bmask[i*BMASK_W +: BMASK_W] & ~clr_mask;
            end else begin
                hold_bmask[i] <= hold_bmask[i] & ~clr_mask;
            end
        end
    end
endmodule
